// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
//   Shared definitions for the RV32I decode stage: the decoded operation
//   class carried down the pipeline, the RV32I base opcodes, the immediate
//   format selector and the immediate builder used by the decoder.
// ---------------------------------------------------------------------------
package id_pkg;

  // Decoded class handed to execute on o_ex_opclass.
  typedef enum logic [3:0] {
    OPC_NONE    = 4'd0,
    OPC_LUI     = 4'd1,
    OPC_AUIPC   = 4'd2,
    OPC_JAL     = 4'd3,
    OPC_JALR    = 4'd4,
    OPC_BRANCH  = 4'd5,
    OPC_LOAD    = 4'd6,
    OPC_STORE   = 4'd7,
    OPC_OP_IMM  = 4'd8,
    OPC_OP      = 4'd9,
    OPC_MISC    = 4'd10,
    OPC_ILLEGAL = 4'd11
  } opclass_e;

  // Immediate layouts of the base ISA.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  // Builds the sign-extended immediate for the given layout; formats that
  // carry no immediate produce zero.
  function automatic logic signed [31:0] imm_gen(input logic [31:0] instr,
                                                 input imm_fmt_e    fmt);
    logic signed [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// ---------------------------------------------------------------------------
// id_decoder
//   Purely combinational RV32I field decoder.
//   Ports:
//     instr    in   32  instruction word
//     opclass  out  4   decoded class (id_pkg::opclass_e encoding)
//     imm      out  32  sign-extended immediate, 0 when the class has none
//     rd       out  5   destination register, 0 when the class writes none
//     use_rs1  out  1   instruction reads rs1
//     use_rs2  out  1   instruction reads rs2
//     illegal  out  1   opcode outside the RV32I base set
// ---------------------------------------------------------------------------
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  opclass,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  opclass_e opc;
  imm_fmt_e fmt;
  logic     has_rd;

  always_comb begin
    opc     = OPC_ILLEGAL;
    fmt     = IMM_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    // Compressed/reserved encodings (instr[1:0] != 11) stay illegal.
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPCODE_LUI: begin
          opc    = OPC_LUI;
          fmt    = IMM_U;
          has_rd = 1'b1;
        end
        OPCODE_AUIPC: begin
          opc    = OPC_AUIPC;
          fmt    = IMM_U;
          has_rd = 1'b1;
        end
        OPCODE_JAL: begin
          opc    = OPC_JAL;
          fmt    = IMM_J;
          has_rd = 1'b1;
        end
        OPCODE_JALR: begin
          opc     = OPC_JALR;
          fmt     = IMM_I;
          use_rs1 = 1'b1;
          has_rd  = 1'b1;
        end
        OPCODE_BRANCH: begin
          opc     = OPC_BRANCH;
          fmt     = IMM_B;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        OPCODE_LOAD: begin
          opc     = OPC_LOAD;
          fmt     = IMM_I;
          use_rs1 = 1'b1;
          has_rd  = 1'b1;
        end
        OPCODE_STORE: begin
          opc     = OPC_STORE;
          fmt     = IMM_S;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        OPCODE_OP_IMM: begin
          opc     = OPC_OP_IMM;
          fmt     = IMM_I;
          use_rs1 = 1'b1;
          has_rd  = 1'b1;
        end
        OPCODE_OP: begin
          opc     = OPC_OP;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          has_rd  = 1'b1;
        end
        // FENCE and SYSTEM pass through as MISC with no register effects
        // visible to the hazard logic.
        OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
          opc = OPC_MISC;
        end
        default: begin
          opc = OPC_ILLEGAL;
        end
      endcase
    end
  end

  assign opclass = opc;
  assign imm     = imm_gen(instr, fmt);
  assign rd      = has_rd ? instr[11:7] : 5'd0;
  assign illegal = (opc == OPC_ILLEGAL);

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   RV32I instruction-decode stage. Accepts one instruction per cycle from
//   fetch, reads the register file combinationally, and registers operands,
//   immediate and control into the ID/EX register. A small shift-register
//   scoreboard of destinations still in flight past ID (EX, MEM) plus the
//   live ID/EX entry is used to stall fetch on read-after-write hazards.
//   Ports:
//     i_clk, i_rst_n     clock, asynchronous active-low reset
//     i_flush            kill ID and the ID/EX register (branch redirect)
//     i_if_valid/o_if_ready/i_if_instr/i_if_pc   fetch handshake
//     o_rs1_addr/o_rs2_addr, i_rs1_data/i_rs2_data   register file read
//     o_ex_valid/i_ex_ready   ID/EX handshake toward execute
//     o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_rd_addr,
//     o_ex_opclass, o_ex_funct3, o_ex_funct7b5, o_ex_illegal   ID/EX fields
// ---------------------------------------------------------------------------
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int INFLIGHT_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [31:0]     i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [31:0]     i_rs1_data,
  input  logic [31:0]     i_rs2_data,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [31:0]     o_ex_rs1_data,
  output logic [31:0]     o_ex_rs2_data,
  output logic [31:0]     o_ex_imm,
  output logic [4:0]      o_ex_rd_addr,
  output logic [3:0]      o_ex_opclass,
  output logic [2:0]      o_ex_funct3,
  output logic            o_ex_funct7b5,
  output logic            o_ex_illegal
);

  logic [3:0]  dec_opclass;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic        dec_illegal;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        advance;
  logic        fire;

  // ID/EX register
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [31:0]     rs1_data_p1;
  logic [31:0]     rs2_data_p1;
  logic [31:0]     imm_p1;
  logic [4:0]      rd_p1;
  logic [3:0]      opclass_p1;
  logic [2:0]      funct3_p1;
  logic            funct7b5_p1;
  logic            illegal_p1;

  // Destination scoreboard: entry 0 is EX, the last entry is the oldest.
  logic [INFLIGHT_DEPTH-1:0] sb_v;
  logic [4:0]                sb_rd [INFLIGHT_DEPTH];

  // ---- ID: decode, register-file read, hazard check ----
  id_decoder u_decoder (
    .instr   (i_if_instr),
    .opclass (dec_opclass),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2),
    .illegal (dec_illegal)
  );

  assign rs1        = i_if_instr[19:15];
  assign rs2        = i_if_instr[24:20];
  assign o_rs1_addr = rs1;
  assign o_rs2_addr = rs2;

  // Entries only ever hold nonzero rd (x0 is filtered on entry), so a
  // match can never be against x0.
  always_comb begin
    hazard = 1'b0;
    if (vld_p1 && (rd_p1 != 5'd0)) begin
      if (dec_use_rs1 && (rs1 == rd_p1)) hazard = 1'b1;
      if (dec_use_rs2 && (rs2 == rd_p1)) hazard = 1'b1;
    end
    for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
      if (sb_v[i]) begin
        if (dec_use_rs1 && (rs1 == sb_rd[i])) hazard = 1'b1;
        if (dec_use_rs2 && (rs2 == sb_rd[i])) hazard = 1'b1;
      end
    end
  end

  assign advance    = !vld_p1 || i_ex_ready;
  assign o_if_ready = !hazard && advance;
  assign fire       = i_if_valid && o_if_ready && !i_flush;

  // ---- ID -> EX boundary ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= fire;
    end else if (i_flush) begin
      vld_p1 <= 1'b0;
    end
  end

  // Fields only change on an accepted instruction; bubbles and stalls hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rd_p1       <= '0;
      opclass_p1  <= OPC_NONE;
      funct3_p1   <= '0;
      funct7b5_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
    end else if (fire) begin
      pc_p1       <= i_if_pc;
      rs1_data_p1 <= i_rs1_data;
      rs2_data_p1 <= i_rs2_data;
      imm_p1      <= dec_imm;
      rd_p1       <= dec_rd;
      opclass_p1  <= dec_opclass;
      funct3_p1   <= i_if_instr[14:12];
      funct7b5_p1 <= i_if_instr[30];
      illegal_p1  <= dec_illegal;
    end
  end

  // ---- EX -> MEM -> WB destination tracking ----
  // A flush does not clear these entries: they belong to older
  // instructions that still write back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb_v <= '0;
      for (int i = 0; i < INFLIGHT_DEPTH; i++) sb_rd[i] <= 5'd0;
    end else if (advance) begin
      sb_v[0]  <= vld_p1 && (rd_p1 != 5'd0);
      sb_rd[0] <= rd_p1;
      for (int i = 1; i < INFLIGHT_DEPTH; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
    end
  end

  assign o_ex_valid    = vld_p1;
  assign o_ex_pc       = pc_p1;
  assign o_ex_rs1_data = rs1_data_p1;
  assign o_ex_rs2_data = rs2_data_p1;
  assign o_ex_imm      = imm_p1;
  assign o_ex_rd_addr  = rd_p1;
  assign o_ex_opclass  = opclass_p1;
  assign o_ex_funct3   = funct3_p1;
  assign o_ex_funct7b5 = funct7b5_p1;
  assign o_ex_illegal  = illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Self-checking bench for id_stage: directed cases for reset, decode,
//   hazards, backpressure, flush and immediates, followed by randomized
//   traffic compared against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_id_stage;
  import id_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [31:0]     rs1_data, rs2_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rd_addr;
  logic [3:0]      ex_opclass;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_illegal;

  always #5 clk = ~clk;

  id_stage #(.XLEN(XLEN), .INFLIGHT_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .i_if_valid    (if_valid),
    .o_if_ready    (if_ready),
    .i_if_instr    (if_instr),
    .i_if_pc       (if_pc),
    .o_rs1_addr    (rs1_addr),
    .o_rs2_addr    (rs2_addr),
    .i_rs1_data    (rs1_data),
    .i_rs2_data    (rs2_data),
    .o_ex_valid    (ex_valid),
    .i_ex_ready    (ex_ready),
    .o_ex_pc       (ex_pc),
    .o_ex_rs1_data (ex_rs1_data),
    .o_ex_rs2_data (ex_rs2_data),
    .o_ex_imm      (ex_imm),
    .o_ex_rd_addr  (ex_rd_addr),
    .o_ex_opclass  (ex_opclass),
    .o_ex_funct3   (ex_funct3),
    .o_ex_funct7b5 (ex_funct7b5),
    .o_ex_illegal  (ex_illegal)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // ID/EX contents plus a list of destinations still in flight past EX
  // (0 meaning "writes nothing"), newest first.
  logic            m_vld;
  logic [XLEN-1:0] m_pc;
  logic [31:0]     m_r1, m_r2, m_imm;
  logic [4:0]      m_rd;
  logic [3:0]      m_opc;
  logic [2:0]      m_f3;
  logic            m_f7;
  logic            m_ill;
  int              m_pending[$];

  task automatic model_reset();
    m_vld = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_rd = 0;
    m_opc = OPC_NONE; m_f3 = 0; m_f7 = 0; m_ill = 0;
    m_pending = {};
    for (int i = 0; i < DEPTH; i++) m_pending.push_back(0);
  endtask

  // Decode from the ISA rules using integer arithmetic on the fields.
  function automatic void ref_dec(input logic [31:0] ins, output logic [3:0] opc,
                                  output logic [31:0] imm, output logic [4:0] rd,
                                  output logic u1, output logic u2);
    int s;
    s = 0; u1 = 0; u2 = 0; opc = OPC_ILLEGAL;
    case (ins[6:0])
      7'h37: opc = OPC_LUI;
      7'h17: opc = OPC_AUIPC;
      7'h6F: opc = OPC_JAL;
      7'h67: begin opc = OPC_JALR;   u1 = 1; end
      7'h63: begin opc = OPC_BRANCH; u1 = 1; u2 = 1; end
      7'h03: begin opc = OPC_LOAD;   u1 = 1; end
      7'h23: begin opc = OPC_STORE;  u1 = 1; u2 = 1; end
      7'h13: begin opc = OPC_OP_IMM; u1 = 1; end
      7'h33: begin opc = OPC_OP;     u1 = 1; u2 = 1; end
      7'h0F, 7'h73: opc = OPC_MISC;
      default: opc = OPC_ILLEGAL;
    endcase
    if (opc inside {OPC_LOAD, OPC_OP_IMM, OPC_JALR}) begin
      s = int'(ins[31:20]);
      if (s >= 2048) s -= 4096;
    end else if (opc == OPC_STORE) begin
      s = int'(ins[31:25]) * 32 + int'(ins[11:7]);
      if (s >= 2048) s -= 4096;
    end else if (opc == OPC_BRANCH) begin
      s = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
        + int'(ins[11:8]) * 2;
      if (s >= 4096) s -= 8192;
    end else if (opc == OPC_JAL) begin
      s = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
        + int'(ins[30:21]) * 2;
      if (s >= 1048576) s -= 2097152;
    end
    imm = 32'(s);
    if (opc inside {OPC_LUI, OPC_AUIPC}) imm = ins & 32'hFFFFF000;
    rd = (opc inside {OPC_BRANCH, OPC_STORE, OPC_MISC, OPC_ILLEGAL}) ? 5'd0 : ins[11:7];
  endfunction

  function automatic logic model_ready();
    logic [3:0]  opc;
    logic [31:0] imm;
    logic [4:0]  rd, a1, a2;
    logic        u1, u2, hz;
    int          busy[$];
    ref_dec(if_instr, opc, imm, rd, u1, u2);
    a1 = if_instr[19:15];
    a2 = if_instr[24:20];
    busy = m_pending;
    if (m_vld) busy.push_back(int'(m_rd));
    hz = 0;
    foreach (busy[k]) begin
      if (busy[k] != 0 && u1 && busy[k] == int'(a1)) hz = 1;
      if (busy[k] != 0 && u2 && busy[k] == int'(a2)) hz = 1;
    end
    return !hz && (!m_vld || ex_ready);
  endfunction

  task automatic model_step(input logic rdy);
    logic [3:0]  opc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        u1, u2, adv, take;
    adv  = !m_vld || ex_ready;
    take = if_valid && rdy && !flush;
    if (adv) begin
      m_pending.push_front(m_vld ? int'(m_rd) : 0);
      void'(m_pending.pop_back());
    end
    if (take) begin
      ref_dec(if_instr, opc, imm, rd, u1, u2);
      m_vld = 1; m_pc = if_pc; m_r1 = rs1_data; m_r2 = rs2_data; m_imm = imm;
      m_rd = rd; m_opc = opc; m_f3 = if_instr[14:12]; m_f7 = if_instr[30];
      m_ill = (opc == OPC_ILLEGAL);
    end else if (adv || flush) begin
      m_vld = 0;
    end
  endtask

  task automatic compare_ex();
    chk("ex_valid", ex_valid, m_vld);
    if (m_vld) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs1_data", ex_rs1_data, m_r1);
      chk("ex_rs2_data", ex_rs2_data, m_r2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rd", ex_rd_addr, m_rd);
      chk("ex_opclass", ex_opclass, m_opc);
      chk("ex_funct3", ex_funct3, m_f3);
      chk("ex_funct7b5", ex_funct7b5, m_f7);
      chk("ex_illegal", ex_illegal, m_ill);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then check
  // the registered outputs just after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic fl, input logic er,
                       output logic rdy);
    logic m_rdy;
    @(negedge clk);
    if_valid = v; if_instr = ins; if_pc = pc; rs1_data = d1;
    rs2_data = $urandom(); ex_ready = er; flush = fl;
    #1;
    m_rdy = model_ready();
    rdy = if_ready;
    chk("if_ready", if_ready, m_rdy);
    chk("rs1_addr", rs1_addr, ins[19:15]);
    chk("rs2_addr", rs2_addr, ins[24:20]);
    model_step(m_rdy);
    @(posedge clk);
    #1;
    compare_ex();
  endtask

  task automatic drain();
    logic r;
    repeat (4) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, r);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 12))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
      4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
      8: op = 7'h33;  9: op = 7'h0F;  10: op = 7'h73; 11: op = 7'h0B;
      default: op = 7'h30;
    endcase
    return {7'($urandom_range(0, 127)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3)), op};
  endfunction

  localparam logic [31:0] ADDI_X1 = 32'hFFB10093; // addi x1,x2,-5
  localparam logic [31:0] ADDI_X0 = 32'hFFB10013; // addi x0,x2,-5
  localparam logic [31:0] ADD_X3  = 32'h001081B3; // add  x3,x1,x1
  localparam logic [31:0] LUI_X5  = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] BEQ_M4  = 32'hFE000EE3; // beq  x0,x0,-4

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int   stalls;
    rst_n = 0; flush = 0; if_valid = 0; if_instr = 0; if_pc = 0;
    rs1_data = 0; rs2_data = 0; ex_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_opclass", ex_opclass, OPC_NONE);
    chk("rst_imm", ex_imm, 0);
    chk("rst_pc", ex_pc, 0);

    // Decode of ADDI and one-cycle latency.
    cycle(1, ADDI_X1, 32'h100, 32'd10, 0, 1, r);
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFB);
    chk("addi_rd", ex_rd_addr, 1);
    chk("addi_rs1", ex_rs1_data, 10);

    // RAW hazard on x1: three stall cycles, then accepted.
    stalls = 0;
    do begin
      cycle(1, ADD_X3, 32'h104, $urandom(), 0, 1, r);
      if (!r) stalls++;
    end while (!r && stalls <= 8);
    chk("raw_stall_cycles", stalls, 3);
    chk("raw_accept_rd", ex_rd_addr, 3);

    // Same pattern writing x0: no stall.
    cycle(1, ADDI_X0, 32'h108, $urandom(), 0, 1, r);
    cycle(1, ADD_X3, 32'h10C, $urandom(), 0, 1, r);
    chk("x0_no_stall", r, 1);
    drain();

    // Backpressure: hold for four cycles, then the next instruction loads.
    cycle(1, ADDI_X1, 32'h200, 32'd7, 0, 1, r);
    for (int i = 0; i < 4; i++) begin
      cycle(1, LUI_X5, 32'h204, $urandom(), 0, 0, r);
      chk("bp_ready", r, 0);
      chk("bp_hold_pc", ex_pc, 32'h200);
      chk("bp_hold_imm", ex_imm, 32'hFFFFFFFB);
    end
    cycle(1, LUI_X5, 32'h204, $urandom(), 0, 1, r);
    chk("bp_release_pc", ex_pc, 32'h204);
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", ex_rd_addr, 5);
    drain();

    // Flush: bubble next cycle, scoreboard still remembers x1.
    cycle(1, ADDI_X1, 32'h300, $urandom(), 0, 1, r);
    cycle(1, LUI_X5, 32'h304, $urandom(), 1, 1, r);
    chk("flush_ex_valid", ex_valid, 0);
    cycle(1, ADD_X3, 32'h308, $urandom(), 0, 1, r);
    chk("flush_sb_kept", r, 0);
    drain();

    // Branch and illegal immediates/flags.
    cycle(1, BEQ_M4, 32'h400, $urandom(), 0, 1, r);
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    chk("beq_rd", ex_rd_addr, 0);
    cycle(1, 32'h0000007F, 32'h404, $urandom(), 0, 1, r);
    chk("ill_flag", ex_illegal, 1);
    chk("ill_opclass", ex_opclass, OPC_ILLEGAL);

    // Reset while stalled drops everything.
    cycle(1, ADDI_X1, 32'h500, $urandom(), 0, 1, r);
    @(negedge clk);
    if_valid = 1; if_instr = ADD_X3; ex_ready = 1; flush = 0;
    #1;
    chk("pre_rst_stall", if_ready, 0);
    rst_n = 0;
    #1;
    chk("midrst_ex_valid", ex_valid, 0);
    chk("midrst_if_ready", if_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle(1, ADD_X3, 32'h504, $urandom(), 0, 1, r);
    chk("post_rst_accept", r, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFFFFFC,
            $urandom(), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
